// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU with a valid/ready command port and a
//            valid/ready result port. Most operations finish in one cycle;
//            divide/modulo use an N-cycle restoring divider when the
//            ALU_SEQ_DIVMOD_EN macro is defined. Without the macro, div/mod
//            complete in one cycle as error results and no divider is built.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_ready - command handshake (a, b, op)
//            a, b [N-1:0]    - operands (b is also the shift amount)
//            op [3:0]        - opcode
//            out_valid/out_ready - result handshake (y, f)
//            y [N-1:0]       - registered result
//            f [4:0]         - flags {error, negative, zero, carry, overflow}
// Config   : `define ALU_SEQ_DIVMOD_EN to build the divider.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [4:0]   f
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b0010;
    localparam logic [3:0] c_OP_DIV = 4'b0011;
    localparam logic [3:0] c_OP_MOD = 4'b0100;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_OR  = 4'b0110;
    localparam logic [3:0] c_OP_XOR = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SHR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] y_q, y_d;
    logic [4:0]   f_q, f_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated directly on the command inputs so
    // the result can be registered at the accept edge.
    // ------------------------------------------------------------------
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_res;
    logic           w_err;
    logic           w_neg;
    logic           w_carry;
    logic           w_ovf;
    logic           w_start_div;

    always_comb begin
        w_sum       = {1'b0, a} + {1'b0, b};
        w_diff      = {1'b0, a} - {1'b0, b};
        w_prod      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        w_res       = '0;
        w_err       = 1'b0;
        w_neg       = 1'b0;
        w_carry     = 1'b0;
        w_ovf       = 1'b0;
        w_start_div = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_neg   = w_sum[N-1];
                // Like-signed operands producing an opposite-signed sum.
                w_ovf   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[N-1:0];
                w_carry = w_diff[N];        // borrow, i.e. a < b
                w_neg   = w_diff[N-1];
                w_ovf   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            c_OP_MUL: begin
                w_res = w_prod[N-1:0];
                w_ovf = |w_prod[2*N-1:N];
            end
            c_OP_DIV, c_OP_MOD: begin
`ifdef ALU_SEQ_DIVMOD_EN
                if (b == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_start_div = 1'b1;
                end
`else
                w_err = 1'b1;
`endif
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            // Logical shifts by >= N already yield zero on an N-bit operand.
            c_OP_SHL: w_res = a << b;
            c_OP_SHR: w_res = a >> b;
            default:  w_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_DIVMOD_EN
    // ------------------------------------------------------------------
    // Restoring divider. quo_q starts as the dividend; each step shifts its
    // MSB into the partial remainder and shifts the new quotient bit in at
    // the LSB, so after N steps quo_q holds the quotient.
    // ------------------------------------------------------------------
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_mod_q, is_mod_d;

    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic          w_fits;
    logic [N-1:0]  w_quo_step;
    logic [N-1:0]  w_rem_step;

    always_comb begin
        w_shift    = {rem_q, quo_q[N-1]};
        w_trial    = w_shift - {1'b0, dvs_q};
        w_fits     = (w_shift >= {1'b0, dvs_q});
        w_quo_step = {quo_q[N-2:0], w_fits};
        // When the divisor fits, the difference is below the divisor and
        // therefore fits in N bits.
        w_rem_step = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        f_d     = f_q;
`ifdef ALU_SEQ_DIVMOD_EN
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        is_mod_d = is_mod_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_DIVMOD_EN
                    if (w_start_div) begin
                        quo_d    = a;
                        rem_d    = '0;
                        dvs_d    = b;
                        cnt_d    = '0;
                        is_mod_d = (op == c_OP_MOD);
                        state_d  = CALC;
                    end else
`endif
                    begin
                        y_d     = w_res;
                        f_d     = {w_err, w_neg, (w_res == '0), w_carry, w_ovf};
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
`ifdef ALU_SEQ_DIVMOD_EN
                quo_d = w_quo_step;
                rem_d = w_rem_step;
                cnt_d = cnt_q + 1'b1;
                // The last quotient bit is produced and registered in the
                // same cycle so DONE follows exactly N CALC cycles.
                if (cnt_q == c_LAST) begin
                    y_d     = is_mod_q ? w_rem_step : w_quo_step;
                    f_d     = {2'b00, ((is_mod_q ? w_rem_step : w_quo_step) == '0), 2'b00};
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            f_q     <= f_d;
        end
    end

`ifdef ALU_SEQ_DIVMOD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_mod_q <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            is_mod_q <= is_mod_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign f         = f_q;

endmodule
`default_nettype wire
